// File: rtl/tone_sequencer.sv
// Frequency-path controller: passes the encoder frequency through while idle,
// or plays a fixed C-major melody with timed notes and optional silent gaps.
module tone_sequencer #(
  parameter int unsigned BEAT_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 1250000,
  parameter int unsigned NUM_NOTES   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        play,
  input  logic        stop,
  input  logic        loop,
  input  logic [31:0] manual_freq,
  input  logic        manual_en,
  output logic [31:0] freq,
  output logic        busy,
  output logic [3:0]  note_idx,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam bit          HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = HAS_GAP ? 32'(GAP_CYCLES - 1) : 32'd0;
  localparam logic [3:0]  LAST_IDX  = 4'(NUM_NOTES - 1);

  state_t      state, state_d;
  logic [31:0] cnt, cnt_d;
  logic [3:0]  idx_d;
  logic [31:0] freq_d;
  logic        busy_d;
  logic        done_d;
  logic        end_note;
  logic [31:0] manual_val;

  // Entry 15 is a rest: a full beat of silence before the pass ends.
  function automatic logic [31:0] rom_freq(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_freq = 32'd262;
      4'd1:    rom_freq = 32'd295;
      4'd2:    rom_freq = 32'd328;
      4'd3:    rom_freq = 32'd349;
      4'd4:    rom_freq = 32'd393;
      4'd5:    rom_freq = 32'd437;
      4'd6:    rom_freq = 32'd491;
      4'd7:    rom_freq = 32'd524;
      4'd8:    rom_freq = 32'd491;
      4'd9:    rom_freq = 32'd437;
      4'd10:   rom_freq = 32'd393;
      4'd11:   rom_freq = 32'd349;
      4'd12:   rom_freq = 32'd328;
      4'd13:   rom_freq = 32'd295;
      4'd14:   rom_freq = 32'd262;
      default: rom_freq = 32'd0;
    endcase
  endfunction

  assign manual_val = manual_en ? manual_freq : 32'd0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 32'd0;
      note_idx <= 4'd0;
      freq     <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      note_idx <= idx_d;
      freq     <= freq_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // The next freq is computed alongside the state so every output is registered.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = note_idx;
    freq_d   = freq;
    done_d   = 1'b0;
    end_note = 1'b0;

    case (state)
      IDLE: begin
        freq_d = manual_val;
        if (play) begin
          state_d = NOTE;
          idx_d   = 4'd0;
          cnt_d   = 32'd0;
          freq_d  = rom_freq(4'd0);
        end
      end
      NOTE: begin
        cnt_d  = cnt + 32'd1;
        freq_d = rom_freq(note_idx);
        if (cnt == BEAT_LAST) begin
          if (HAS_GAP) begin
            state_d = GAP;
            cnt_d   = 32'd0;
            freq_d  = 32'd0;
          end else begin
            end_note = 1'b1;
          end
        end
      end
      GAP: begin
        cnt_d  = cnt + 32'd1;
        freq_d = 32'd0;
        if (cnt == GAP_LAST) end_note = 1'b1;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
        cnt_d   = 32'd0;
        freq_d  = 32'd0;
      end
    endcase

    if (end_note) begin
      cnt_d = 32'd0;
      if (note_idx < LAST_IDX) begin
        state_d = NOTE;
        idx_d   = note_idx + 4'd1;
        freq_d  = rom_freq(note_idx + 4'd1);
      end else if (loop) begin
        state_d = NOTE;
        idx_d   = 4'd0;
        freq_d  = rom_freq(4'd0);
      end else begin
        state_d = IDLE;
        idx_d   = 4'd0;
        freq_d  = manual_val;
        done_d  = 1'b1;
      end
    end

    // stop wins over everything, including a pass that is just completing.
    if (stop) begin
      state_d = IDLE;
      idx_d   = 4'd0;
      cnt_d   = 32'd0;
      freq_d  = manual_val;
      done_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: two builds (with and without gaps) share the
// stimulus and are compared each cycle against a time-based melody model.
module tb_tone_sequencer;

  localparam int unsigned BEAT = 4;
  localparam int unsigned NUM  = 16;

  logic        clk;
  logic        reset_n;
  logic        play;
  logic        stop;
  logic        loop;
  logic [31:0] manual_freq;
  logic        manual_en;

  logic [31:0] freq_g2, freq_g0;
  logic        busy_g2, busy_g0;
  logic [3:0]  idx_g2, idx_g0;
  logic        done_g2, done_g0;

  int pass_count;
  int check_count;

  int unsigned rom_table [16] = '{262, 295, 328, 349, 393, 437, 491, 524,
                                  491, 437, 393, 349, 328, 295, 262, 0};
  int unsigned gap_of [2] = '{2, 0};

  bit          m_playing [2];
  int unsigned m_t       [2];
  int unsigned m_freq    [2];
  bit          m_busy    [2];
  int unsigned m_idx     [2];
  bit          m_done    [2];

  tone_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(2), .NUM_NOTES(NUM)) dut_gap (
    .clk(clk), .reset_n(reset_n), .play(play), .stop(stop), .loop(loop),
    .manual_freq(manual_freq), .manual_en(manual_en),
    .freq(freq_g2), .busy(busy_g2), .note_idx(idx_g2), .done(done_g2)
  );

  tone_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(0), .NUM_NOTES(NUM)) dut_nogap (
    .clk(clk), .reset_n(reset_n), .play(play), .stop(stop), .loop(loop),
    .manual_freq(manual_freq), .manual_en(manual_en),
    .freq(freq_g0), .busy(busy_g0), .note_idx(idx_g0), .done(done_g0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
  endtask

  // The model tracks elapsed time within a pass; note and silence follow from division.
  task automatic modelStep(input int k);
    int unsigned period;
    int unsigned pass_len;
    int unsigned man;
    period   = BEAT + gap_of[k];
    pass_len = NUM * period;
    man      = manual_en ? manual_freq : 0;
    m_done[k] = 1'b0;
    if (!reset_n) begin
      m_playing[k] = 1'b0;
      m_freq[k]    = 0;
      m_idx[k]     = 0;
    end else if (stop) begin
      m_playing[k] = 1'b0;
      m_freq[k]    = man;
      m_idx[k]     = 0;
    end else if (!m_playing[k]) begin
      if (play) begin
        m_playing[k] = 1'b1;
        m_t[k]       = 0;
      end else begin
        m_freq[k] = man;
      end
    end else begin
      m_t[k]++;
      if (m_t[k] == pass_len) begin
        if (loop) begin
          m_t[k] = 0;
        end else begin
          m_playing[k] = 1'b0;
          m_done[k]    = 1'b1;
          m_idx[k]     = 0;
          m_freq[k]    = man;
        end
      end
    end
    if (m_playing[k]) begin
      m_idx[k]  = m_t[k] / period;
      m_freq[k] = ((m_t[k] % period) < BEAT) ? rom_table[m_idx[k]] : 0;
    end
    m_busy[k] = m_playing[k];
  endtask

  task automatic applyStimulus(input logic rst_v, input logic play_v, input logic stop_v,
                               input logic loop_v, input logic en_v,
                               input logic [31:0] mf_v);
    @(negedge clk);
    reset_n     = rst_v;
    play        = play_v;
    stop        = stop_v;
    loop        = loop_v;
    manual_en   = en_v;
    manual_freq = mf_v;
    @(posedge clk);
    #1;
    modelStep(0);
    modelStep(1);
    checkOutput("g2_freq", freq_g2, m_freq[0]);
    checkOutput("g2_busy", {31'd0, busy_g2}, {31'd0, m_busy[0]});
    checkOutput("g2_idx", {28'd0, idx_g2}, m_idx[0]);
    checkOutput("g2_done", {31'd0, done_g2}, {31'd0, m_done[0]});
    checkOutput("g0_freq", freq_g0, m_freq[1]);
    checkOutput("g0_busy", {31'd0, busy_g0}, {31'd0, m_busy[1]});
    checkOutput("g0_idx", {28'd0, idx_g0}, m_idx[1]);
    checkOutput("g0_done", {31'd0, done_g0}, {31'd0, m_done[1]});
  endtask

  task automatic idleCycles(input int n, input logic loop_v, input logic en_v,
                            input logic [31:0] mf_v);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, loop_v, en_v, mf_v);
  endtask

  initial begin
    int len_g2;
    int len_g0;
    int dones_g2;
    logic loop_r;
    logic en_r;
    logic [31:0] mf_r;

    pass_count  = 0;
    check_count = 0;
    reset_n = 1'b0; play = 1'b0; stop = 1'b0; loop = 1'b0;
    manual_en = 1'b0; manual_freq = 32'd0;
    for (int k = 0; k < 2; k++) begin
      m_playing[k] = 1'b0; m_t[k] = 0; m_freq[k] = 0;
      m_busy[k] = 1'b0; m_idx[k] = 0; m_done[k] = 1'b0;
    end

    $display("[TB] reset and idle passthrough");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd777);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd777);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd393);
    checkOutput("passthru_393", freq_g2, 32'd393);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd393);

    $display("[TB] single pass");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    len_g2 = 0; len_g0 = 0;
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      if (done_g2 && len_g2 == 0) len_g2 = i;
      if (done_g0 && len_g0 == 0) len_g0 = i;
    end
    checkOutput("pass_len_g2", len_g2, 96);
    checkOutput("pass_len_g0", len_g0, 64);

    $display("[TB] looping");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    dones_g2 = 0;
    for (int i = 1; i <= 126; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      if (done_g2) dones_g2++;
    end
    len_g2 = 0;
    for (int i = 127; i <= 200; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      if (done_g2) dones_g2++;
      if (done_g2 && len_g2 == 0) len_g2 = i;
    end
    checkOutput("loop_done_count", dones_g2, 1);
    checkOutput("loop_done_at", len_g2, 192);

    $display("[TB] stop mid-note");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd600);
    idleCycles(31, 1'b0, 1'b1, 32'd600);
    checkOutput("pre_stop_freq", freq_g2, 32'd437);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd600);
    checkOutput("post_stop_freq", freq_g2, 32'd600);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    idleCycles(3, 1'b0, 1'b0, 32'd0);

    $display("[TB] play while busy");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd524);
    idleCycles(18, 1'b0, 1'b1, 32'd524);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd524);
    idleCycles(6, 1'b0, 1'b1, 32'd524);
    checkOutput("no_restart_idx", {28'd0, idx_g2}, 32'd4);

    $display("[TB] reset during gap");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    idleCycles(4, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd111);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd111);

    $display("[TB] randomized traffic");
    loop_r = 1'b0; en_r = 1'b0; mf_r = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) loop_r = ~loop_r;
      if ($urandom_range(0, 19) == 0) en_r = ~en_r;
      if ($urandom_range(0, 9) == 0) mf_r = 32'($urandom_range(0, 65535));
      applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 79) == 0, loop_r, en_r, mf_r);
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Controller for the tone-generator frequency path.
- Arbitrates between the manual encoder-selected frequency and an internal melody player that steps through a fixed C-major note table with timed notes and silent gaps.
- Output `freq` drives the tone generator directly, replacing the encoder frequency at its input.
- Sits between the encoder-to-frequency block and the tone generator.

Parameters:
- BEAT_CYCLES, 12500000, clk cycles each note sounds (250 ms at 50 MHz); legal ≥ 1.
- GAP_CYCLES, 1250000, clk cycles of silence after each note; 0 means no gap.
- NUM_NOTES, 16, melody table entries played per pass; legal 1..16.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- play  in  1  one-cycle start request.
- stop  in  1  one-cycle abort request.
- loop  in  1  level; when 1, melody restarts after the last entry.
- manual_freq  in  32  frequency in Hz from the encoder mapping block.
- manual_en  in  1  level; manual_freq passes to freq while the sequencer is idle.
- freq  out  32  frequency in Hz to the tone generator; 0 = silent.
- busy  out  1  high while the melody is playing (NOTE or GAP).
- note_idx  out  4  current table index.
- done  out  1  one-cycle pulse when a non-looping pass completes.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, freq=0, busy=0, note_idx=0, done=0, duration counter=0. Reset overrides play/stop in the same cycle.
- Melody table, fixed ROM, index 0..15:
  - 262, 295, 328, 349, 393, 437, 491, 524, 491, 437, 393, 349, 328, 295, 262, 0.
  - Entry 15 is a rest (freq 0 for a full beat).
- All outputs are registered. Values shown are those after the posedge on which the transition is taken.
- State IDLE:
  - freq = manual_en ? manual_freq : 0, updated every cycle (1-cycle latency); busy=0.
  - play=1 and stop=0 → NOTE, note_idx=0, cnt=0, freq=ROM[0].
- State NOTE:
  - freq = ROM[note_idx]; cnt increments each cycle.
  - At cnt==BEAT_CYCLES-1, next state is:
    - GAP with cnt=0 and freq=0, if GAP_CYCLES>0;
    - otherwise the end-of-note action below.
- State GAP:
  - freq=0; cnt increments each cycle.
  - At cnt==GAP_CYCLES-1 → end-of-note action.
- End-of-note action:
  - note_idx<NUM_NOTES-1 → note_idx+1, NOTE, cnt=0.
  - note_idx==NUM_NOTES-1 and loop=1 → note_idx=0, NOTE, cnt=0.
  - note_idx==NUM_NOTES-1 and loop=0 → IDLE, note_idx=0, done=1 for exactly one cycle. freq takes the manual/0 value in the same cycle.
- loop is sampled only at the end-of-note action on the last entry.
- Each note period is exactly BEAT_CYCLES+GAP_CYCLES cycles. One pass is NUM_NOTES*(BEAT_CYCLES+GAP_CYCLES) cycles.
- stop=1 in any state → IDLE next cycle, note_idx=0, cnt=0, no done pulse. stop has priority over play when both are asserted.
- play while busy is ignored; no restart.
- manual_en and manual_freq are ignored while busy; the sequencer owns freq.
- Counter is 32 bits and never wraps within legal parameters.

Test Plan:
Bench parameters for all scenarios: BEAT_CYCLES=4, GAP_CYCLES=2, NUM_NOTES=16.
1. Reset and idle passthrough:
   - reset_n=0 for 2 cycles → freq=0, busy=0, note_idx=0.
   - Release reset; manual_en=1, manual_freq=393 → freq=393 one cycle later.
   - manual_en=0 → freq=0.
2. Single pass:
   - loop=0; pulse play.
   - freq=262 for 4 cycles, then 0 for 2, then 295 for 4, and so on through the table.
   - Entry 15 gives 0 for 6 cycles.
   - Cycle 96 after play: done=1 for one cycle, busy=0.
3. Looping:
   - loop=1; play → after entry 15, note_idx=0 and freq=262 with no done pulse.
   - Drop loop during pass 2 → done at the end of pass 2 only.
4. Stop mid-note:
   - play; stop on cycle 2 of note index 5 (freq=437) → next cycle freq=manual/0, busy=0, note_idx=0, done=0.
   - Simultaneous play+stop in IDLE → stays IDLE.
5. Play while busy:
   - Pulse play at note_idx=3 → sequence continues unchanged (note_idx=4 next, no restart).
   - manual_en=1, manual_freq=524 during NOTE → freq stays at the ROM value.
6. Reset mid-operation and GAP_CYCLES=0 variant:
   - reset_n=0 during GAP → IDLE, freq=0 next cycle.
   - Separate build with GAP_CYCLES=0 → notes are back-to-back, 4 cycles each, and the pass is 64 cycles.
